// File: rtl/aes_pkg.sv
// Shared AES constants, control-state encodings and GF(2^8) column helpers.
// Pure combinational functions only; no state, no flow control.
package aes_pkg;

    localparam int AES_128_NUM_ROUNDS = 10;

    typedef logic [2:0] ctrl_state_t;
    localparam logic [2:0] CTRL_IDLE = 3'd0;
    localparam logic [2:0] CTRL_INIT = 3'd1;
    localparam logic [2:0] CTRL_SBOX = 3'd2;
    localparam logic [2:0] CTRL_MAIN = 3'd3;

    // xtime: multiply by x modulo 0x11b
    function automatic logic [7:0] gm2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm4(input logic [7:0] x);
        return gm2(gm2(x));
    endfunction

    function automatic logic [7:0] gm8(input logic [7:0] x);
        return gm2(gm4(x));
    endfunction

    function automatic logic [7:0] gm9(input logic [7:0] x);
        return gm8(x) ^ x;
    endfunction

    function automatic logic [7:0] gm11(input logic [7:0] x);
        return gm8(x) ^ gm2(x) ^ x;
    endfunction

    function automatic logic [7:0] gm13(input logic [7:0] x);
        return gm8(x) ^ gm4(x) ^ x;
    endfunction

    function automatic logic [7:0] gm14(input logic [7:0] x);
        return gm8(x) ^ gm4(x) ^ gm2(x);
    endfunction

    function automatic logic [31:0] inv_mixw(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        b0 = w[31:24];
        b1 = w[23:16];
        b2 = w[15:8];
        b3 = w[7:0];
        return {gm14(b0) ^ gm11(b1) ^ gm13(b2) ^ gm9(b3),
                gm9(b0)  ^ gm14(b1) ^ gm11(b2) ^ gm13(b3),
                gm13(b0) ^ gm9(b1)  ^ gm14(b2) ^ gm11(b3),
                gm11(b0) ^ gm13(b1) ^ gm9(b2)  ^ gm14(b3)};
    endfunction

    function automatic logic [127:0] inv_mixcolumns(input logic [127:0] s);
        return {inv_mixw(s[127:96]), inv_mixw(s[95:64]),
                inv_mixw(s[63:32]), inv_mixw(s[31:0])};
    endfunction

    // Row r of each output column comes from column (c - r) mod 4
    function automatic logic [127:0] inv_shiftrows(input logic [127:0] s);
        return {s[127:120], s[23:16],   s[47:40],  s[71:64],
                s[95:88],   s[119:112], s[15:8],   s[39:32],
                s[63:56],   s[87:80],   s[111:104], s[7:0],
                s[31:24],   s[55:48],   s[79:72],  s[103:96]};
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Four parallel AES inverse S-box lookups on one 32-bit word.
// Combinational, zero latency, no flow control.
module aes_inv_sbox (
    input  logic [31:0] sword,
    output logic [31:0] new_sword
);

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad5_3036a538_bf40a39e_81f3d7fb,
        128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
        128'h547b9432_a6c2233d_ee4c950b_42fac34e,
        128'h082ea166_28d924b2_765ba249_6d8bd125,
        128'h72f8f664_86689816_d4a45ccc_5d65b692,
        128'h6c704850_fdedb9da_5e154657_a78d9d84,
        128'h90d8ab00_8cbcd30a_f7e45805_b8b34506,
        128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
        128'h3a911141_4f67dcea_97f2cfce_f0b4e673,
        128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
        128'h47f11a71_1d29c589_6fb7620e_aa18be1b,
        128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
        128'h1fdda833_8807c731_b1121059_2780ec5f,
        128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
        128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961,
        128'h172b047e_ba77d626_e1691463_55210c7d
    };

    // Entry 0 sits in the top byte, so entry x starts at bit 8*(255-x) = {~x, 3'b000}
    function automatic logic [7:0] inv_sb(input logic [7:0] x);
        return INV_SBOX[{~x, 3'b000} +: 8];
    endfunction

    always_comb begin
        new_sword = {inv_sb(sword[31:24]), inv_sb(sword[23:16]),
                     inv_sb(sword[15:8]),  inv_sb(sword[7:0])};
    end

endmodule

// File: rtl/aes_decipher_block.sv
// Iterative AES-128 inverse cipher: 52 cycles per block, 22 with AES_DEC_PARALLEL_SBOX_EN.
// No backpressure: next is ignored while ready is low; result holds until the next accept.
module aes_decipher_block
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    ctrl_state_t  state_q, state_d;
    logic [3:0]   round_ctr_q, round_ctr_d;
    logic [1:0]   word_ctr_q, word_ctr_d;
    logic [127:0] block_reg_q, block_reg_d;
    logic         ready_q, ready_d;

    logic [127:0] sbox_block;
    logic         sbox_last;
    logic [127:0] add_block;

`ifdef AES_DEC_PARALLEL_SBOX_EN
    for (genvar w = 0; w < 4; w++) begin : g_sbox
        aes_inv_sbox u_inv_sbox (
            .sword     (block_reg_q[127-32*w -: 32]),
            .new_sword (sbox_block[127-32*w -: 32])
        );
    end

    assign sbox_last = 1'b1;
`else
    logic [31:0] sbox_in;
    logic [31:0] sbox_out;

    aes_inv_sbox u_inv_sbox (
        .sword     (sbox_in),
        .new_sword (sbox_out)
    );

    // One word per cycle, substituted in place
    always_comb begin
        sbox_block = block_reg_q;
        sbox_in    = block_reg_q[127:96];
        case (word_ctr_q)
            2'd0: begin sbox_in = block_reg_q[127:96]; sbox_block[127:96] = sbox_out; end
            2'd1: begin sbox_in = block_reg_q[95:64];  sbox_block[95:64]  = sbox_out; end
            2'd2: begin sbox_in = block_reg_q[63:32];  sbox_block[63:32]  = sbox_out; end
            default: begin sbox_in = block_reg_q[31:0]; sbox_block[31:0] = sbox_out; end
        endcase
    end

    assign sbox_last = (word_ctr_q == 2'd3);
`endif

    // InvSubBytes already ran in CTRL_SBOX; it commutes with InvShiftRows
    assign add_block = inv_shiftrows(block_reg_q) ^ round_key;

    always_comb begin
        state_d     = state_q;
        round_ctr_d = round_ctr_q;
        word_ctr_d  = word_ctr_q;
        block_reg_d = block_reg_q;
        ready_d     = ready_q;

        case (state_q)
            CTRL_IDLE: begin
                if (next) begin
                    block_reg_d = block;
                    round_ctr_d = 4'(AES_128_NUM_ROUNDS);
                    ready_d     = 1'b0;
                    state_d     = CTRL_INIT;
                end
            end
            CTRL_INIT: begin
                block_reg_d = block_reg_q ^ round_key;
                round_ctr_d = 4'(AES_128_NUM_ROUNDS - 1);
                word_ctr_d  = 2'd0;
                state_d     = CTRL_SBOX;
            end
            CTRL_SBOX: begin
                block_reg_d = sbox_block;
`ifndef AES_DEC_PARALLEL_SBOX_EN
                word_ctr_d  = word_ctr_q + 2'd1;
`endif
                if (sbox_last) begin
                    state_d = CTRL_MAIN;
                end
            end
            CTRL_MAIN: begin
                if (round_ctr_q != 4'd0) begin
                    block_reg_d = inv_mixcolumns(add_block);
                    round_ctr_d = round_ctr_q - 4'd1;
                    word_ctr_d  = 2'd0;
                    state_d     = CTRL_SBOX;
                end else begin
                    block_reg_d = add_block;
                    ready_d     = 1'b1;
                    state_d     = CTRL_IDLE;
                end
            end
            default: begin
                ready_d = 1'b1;
                state_d = CTRL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= CTRL_IDLE;
            round_ctr_q <= 4'd0;
            word_ctr_q  <= 2'd0;
            block_reg_q <= '0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            round_ctr_q <= round_ctr_d;
            word_ctr_q  <= word_ctr_d;
            block_reg_q <= block_reg_d;
            ready_q     <= ready_d;
        end
    end

    assign round     = round_ctr_q;
    assign new_block = block_reg_q;
    assign ready     = ready_q;

endmodule

// File: tb/tb_aes_decipher_block.sv
// Directed bench for aes_decipher_block against FIPS-197 vectors with a modelled key memory.
module tb_aes_decipher_block;

`ifdef AES_DEC_PARALLEL_SBOX_EN
    localparam int LAT = 22;
`else
    localparam int LAT = 52;
`endif

    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] A1_CT = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] A1_PT = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk;
    logic         reset_n;
    logic         next;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [127:0] block;
    logic [127:0] new_block;
    logic         ready;

    logic         key_sel;
    int           n_checks;
    int           n_pass;
    bit           log_en;
    logic [3:0]   round_log[$];

    // Expanded schedules for key 000102..0f (sel 0) and 2b7e..4f3c (sel 1)
    logic [127:0] rk_c1 [0:10] = '{
        128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5};
    logic [127:0] rk_a1 [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    aes_decipher_block dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .next      (next),
        .round     (round),
        .round_key (round_key),
        .block     (block),
        .new_block (new_block),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        round_key = '0;
        if (round <= 4'd10) round_key = key_sel ? rk_a1[round] : rk_c1[round];
    end

    always begin
        @(posedge clk);
        #1;
        if (log_en && (round_log.size() == 0 || round_log[$] != round))
            round_log.push_back(round);
    end

    // Counts edges from the accepting edge (1) to the edge on which ready rises
    task automatic run_op(input logic [127:0] blk, input logic sel,
                          output logic [127:0] res, output int lat);
        @(negedge clk);
        block   = blk;
        key_sel = sel;
        next    = 1'b1;
        @(posedge clk);
        #1;
        lat  = 1;
        next = 1'b0;
        while (ready !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = new_block;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (ready !== 1'b1) $display("FAIL reset_ready cyc%0d got %b want 1", i, ready);
            else n_pass++;
            n_checks++;
            if (new_block !== 128'h0) $display("FAIL reset_new_block cyc%0d got %h want 0", i, new_block);
            else n_pass++;
            n_checks++;
            if (round !== 4'd0) $display("FAIL reset_round cyc%0d got %0d want 0", i, round);
            else n_pass++;
        end
    endtask

    task automatic test_fips_c1();
        logic [127:0] res;
        int lat;
        run_op(C1_CT, 1'b0, res, lat);
        n_checks++;
        if (res !== C1_PT) $display("FAIL c1_result got %h want %h", res, C1_PT);
        else n_pass++;
        n_checks++;
        if (lat !== LAT) $display("FAIL c1_latency got %0d want %0d", lat, LAT);
        else n_pass++;
    endtask

    task automatic test_fips_a1_rounds();
        logic [127:0] res;
        int lat;
        bit seq_ok;
        round_log.delete();
        log_en = 1'b1;
        run_op(A1_CT, 1'b1, res, lat);
        log_en = 1'b0;
        n_checks++;
        if (res !== A1_PT) $display("FAIL a1_result got %h want %h", res, A1_PT);
        else n_pass++;
        n_checks++;
        if (lat !== LAT) $display("FAIL a1_latency got %0d want %0d", lat, LAT);
        else n_pass++;
        seq_ok = (round_log.size() == 11);
        for (int i = 0; i < round_log.size() && i < 11; i++)
            if (round_log[i] !== 4'(10 - i)) seq_ok = 1'b0;
        n_checks++;
        if (!seq_ok) $display("FAIL round_sequence got %p want 10 down to 0", round_log);
        else n_pass++;
    endtask

    task automatic test_ignore_next();
        int lat;
        @(negedge clk);
        block   = C1_CT;
        key_sel = 1'b0;
        next    = 1'b1;
        @(posedge clk);
        #1;
        lat  = 1;
        next = 1'b0;
        while (lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        next  = 1'b1;
        block = A1_CT;
        @(posedge clk);
        #1;
        lat++;
        next = 1'b0;
        n_checks++;
        if (ready !== 1'b0) $display("FAIL ignore_ready_low got %b want 0", ready);
        else n_pass++;
        while (ready !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_checks++;
        if (new_block !== C1_PT) $display("FAIL ignore_result got %h want %h", new_block, C1_PT);
        else n_pass++;
        n_checks++;
        if (lat !== LAT) $display("FAIL ignore_latency got %0d want %0d", lat, LAT);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [127:0] res;
        int lat;
        @(negedge clk);
        block   = A1_CT;
        key_sel = 1'b1;
        next    = 1'b1;
        @(posedge clk);
        #1;
        lat  = 1;
        next = 1'b0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (ready !== 1'b1) $display("FAIL midreset_ready got %b want 1", ready);
        else n_pass++;
        n_checks++;
        if (new_block !== 128'h0) $display("FAIL midreset_new_block got %h want 0", new_block);
        else n_pass++;
        n_checks++;
        if (round !== 4'd0) $display("FAIL midreset_round got %0d want 0", round);
        else n_pass++;
        reset_n = 1'b1;
        run_op(C1_CT, 1'b0, res, lat);
        n_checks++;
        if (res !== C1_PT) $display("FAIL midreset_rerun got %h want %h", res, C1_PT);
        else n_pass++;
        n_checks++;
        if (lat !== LAT) $display("FAIL midreset_latency got %0d want %0d", lat, LAT);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [127:0] cts [3] = '{C1_CT, A1_CT, C1_CT};
        logic [127:0] pts [3] = '{C1_PT, A1_PT, C1_PT};
        logic         sels [3] = '{1'b0, 1'b1, 1'b0};
        int lat;
        @(negedge clk);
        block   = cts[0];
        key_sel = sels[0];
        next    = 1'b1;
        @(posedge clk);
        #1;
        lat = 1;
        for (int k = 0; k < 3; k++) begin
            while (ready !== 1'b1 && lat < 200) begin
                @(posedge clk);
                #1;
                lat++;
            end
            n_checks++;
            if (new_block !== pts[k]) $display("FAIL b2b_result%0d got %h want %h", k, new_block, pts[k]);
            else n_pass++;
            n_checks++;
            if (lat !== LAT) $display("FAIL b2b_latency%0d got %0d want %0d", k, lat, LAT);
            else n_pass++;
            if (k < 2) begin
                block   = cts[k+1];
                key_sel = sels[k+1];
            end else begin
                next = 1'b0;
            end
            @(posedge clk);
            #1;
            lat = 1;
            n_checks++;
            if (ready !== (k == 2)) $display("FAIL b2b_ready_window%0d got %b want %b", k, ready, (k == 2));
            else n_pass++;
        end
        n_checks++;
        if (new_block !== C1_PT) $display("FAIL b2b_hold got %h want %h", new_block, C1_PT);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        log_en   = 1'b0;
        reset_n  = 1'b0;
        next     = 1'b0;
        block    = '0;
        key_sel  = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_fips_c1();
        test_fips_a1_rounds();
        test_ignore_next();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_decipher_block.md
# aes_decipher_block

Iterative AES-128 inverse cipher datapath that reads the expanded round keys from the key memory, highest index first. It drives the key memory's `round` index and consumes the combinational `round_key` it returns. It turns one 128-bit ciphertext block into plaintext over a fixed number of cycles. It sits beside the key memory in the AES core and is started by the core's `next` strobe once key expansion reports ready.

## Interface
Parameters: none. AES-128 only; 10 rounds fixed.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge
- `reset_n`  in  1  reset, synchronous and active-low
- `next`  in  1  start strobe; sampled only while `ready`=1
- `round`  out  4  round-key index presented to the key memory
- `round_key`  in  128  key-memory word for `round`, combinational, valid same cycle
- `block`  in  128  ciphertext; captured on the accepting edge
- `new_block`  out  128  plaintext; valid while `ready`=1 after a completed operation
- `ready`  out  1  1 = idle and result valid / able to accept `next`

## Operation
- Byte order follows FIPS-197: byte 0 = `[127:120]`; column c = word c; word 0 = `[127:96]`.
- `round_ctr` (4 bit) drives `round` directly.
- `word_ctr` (2 bit) selects the S-box word.
- FSM states: CTRL_IDLE, CTRL_INIT, CTRL_SBOX, CTRL_MAIN.
- **CTRL_IDLE**: `ready`=1.
  - On `next`=1: `block_reg`<=`block`, `round_ctr`<=10, `ready`<=0, go to CTRL_INIT.
- **CTRL_INIT**: `block_reg`<=`block_reg`^`round_key` (uses round key 10).
  - `round_ctr`<=9, `word_ctr`<=0, go to CTRL_SBOX.
- **CTRL_SBOX**: in-place InvSubBytes on `block_reg` (word-serial; see Configuration).
  - Go to CTRL_MAIN after the last word.
- **CTRL_MAIN**: t = InvShiftRows(`block_reg`) ^ `round_key`.
  - If `round_ctr`!=0: `block_reg`<=InvMixColumns(t), `round_ctr`--, `word_ctr`<=0, go to CTRL_SBOX.
  - If `round_ctr`==0: `block_reg`<=t, `ready`<=1, go to CTRL_IDLE.
  - InvShiftRows is applied after InvSubBytes; this is legal because the two steps commute.
- `new_block` is a continuous copy of `block_reg`.
- InvMixColumns uses GF(2^8) multiplication by 9, 11, 13, 14 with polynomial 0x11b; all arithmetic is 8-bit, with no carry.

Boundary conditions:
- `next` while `ready`=0 is ignored, with no restart.
- `block` changes after the accepting edge have no effect.
- `next` held high continuously starts a new operation on the edge after `ready` rises; the result stays visible for one cycle.
- `reset_n`=0 mid-operation aborts on the next edge, with no partial output.
- Unused FSM encodings return to CTRL_IDLE.

## Timing
- Reset values: `ready`=1, `new_block`=0, `round`=0, FSM=CTRL_IDLE, `word_ctr`=0.
- Latency: S = S-box cycles per round (4 by default, 1 with the macro).
- `ready` rises 2+10·(S+1) edges after the edge sampling `next`:
  - default: 52 cycles.
  - with macro: 22 cycles.
- `new_block` is valid on the same edge `ready` rises and holds until the next accepted `next`.
- `round` changes only on clock edges. `round_key` is treated as combinational from `round` within the cycle, so there is no extra wait state.

## Configuration
- Macro: `AES_DEC_PARALLEL_SBOX_EN`.
- Undefined (default): one `aes_inv_sbox` instance.
  - CTRL_SBOX substitutes word `word_ctr` per cycle, 4 cycles per round.
  - Leaves when `word_ctr`==3.
- Defined: four instances.
  - CTRL_SBOX substitutes all words in one cycle.
  - `word_ctr` is unused and held at 0.
- Functional results are identical in both builds; only latency differs.

## Structure
- Shared package `aes_pkg` holds:
  - `AES_128_NUM_ROUNDS`=10
  - FSM state typedef/encodings
  - GF(2^8) helpers `gm2`, `gm4`, `gm8`, `gm9`, `gm11`, `gm13`, `gm14`
  - `inv_mixw` (one column) and `inv_shiftrows` functions
- One sub-module, `aes_inv_sbox`: combinational, 32-bit word in, 32-bit out, four 256-entry inverse S-box lookups.

## Test plan
- Reset release, hold idle 5 cycles -> `ready`=1, `new_block`=0, `round`=0 throughout.
- Keys from key memory with key `000102030405060708090a0b0c0d0e0f`; `block`=`69c4e0d86a7b0430d8cdb78070b4c55a`, pulse `next` -> `new_block`=`00112233445566778899aabbccddeeff`, `ready` rising at cycle 52 (22 with macro).
- Key `2b7e151628aed2a6abf7158809cf4f3c`; `block`=`3925841d02dc09fbdc118597196a0b32` -> `new_block`=`3243f6a8885a308d313198a2e0370734`. Check that `round` steps 10,9,…,0.
- Pulse `next` at cycle 10 of an operation with a different `block` -> ignored; result and latency match the first operation.
- Assert `reset_n`=0 at cycle 20, release, then rerun the first vector -> `ready`=1 and `new_block`=0 immediately after reset; the rerun gives the correct result.
- `next` held high for 3 back-to-back operations -> three correct results; `ready` high exactly one cycle between them.
